// File: rtl/icache_rom.sv
// rtl/icache_rom.sv - read-only direct-mapped instruction cache refilled from ROM
module icache_rom #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    // fetch side (cache is the secondary)
    input  logic                     wish_s_proc_cyc,
    input  logic                     wish_s_proc_stb,
    input  logic                     wish_s_proc_we,
    input  logic [DATA_SIZE/8-1:0]   wish_s_proc_sel,
    input  logic                     wish_s_proc_tgd,
    input  logic [ADDR_SIZE-1:0]     wish_s_proc_addr,
    input  logic [DATA_SIZE-1:0]     wish_s_proc_dat_o_s,
    output logic                     wish_s_proc_ack,
    output logic [DATA_SIZE-1:0]     wish_s_proc_dat_i_s,
    // ROM side (cache is the primary)
    output logic                     wish_p_rom_cyc,
    output logic                     wish_p_rom_stb,
    output logic                     wish_p_rom_we,
    output logic [DATA_SIZE/8-1:0]   wish_p_rom_sel,
    output logic                     wish_p_rom_tgd,
    output logic [ADDR_SIZE-1:0]     wish_p_rom_addr,
    output logic [DATA_SIZE-1:0]     wish_p_rom_dat_i_p,
    input  logic                     wish_p_rom_ack,
    input  logic [DATA_SIZE-1:0]     wish_p_rom_dat_o_p
);
    localparam int BYTES  = DATA_SIZE / 8;
    localparam int BYTE_W = $clog2(BYTES);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int CNT_W  = (LINE_WORDS > 1) ? WORD_W : 1;
    localparam int IDX_W  = $clog2(LINES);
    localparam int LSH    = BYTE_W + WORD_W;
    localparam int TAG_W  = ADDR_SIZE - LSH - IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, HIT_ACK, WR_ACK, REFILL, RESP} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [DATA_SIZE-1:0]   data_mem [LINES][LINE_WORDS];
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [CNT_W-1:0]       cnt;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_SIZE-1:0] a);
        return IDX_W'(a >> LSH);
    endfunction

    function automatic logic [CNT_W-1:0] word_of(input logic [ADDR_SIZE-1:0] a);
        return CNT_W'((a >> BYTE_W) & ADDR_SIZE'(LINE_WORDS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_SIZE-1:0] a);
        return TAG_W'(a >> (LSH + IDX_W));
    endfunction

    function automatic logic [ADDR_SIZE-1:0] line_base(input logic [ADDR_SIZE-1:0] a);
        return (a >> LSH) << LSH;
    endfunction

    logic [IDX_W-1:0] proc_idx, req_idx;
    logic [CNT_W-1:0] proc_word, req_word;
    logic [TAG_W-1:0] proc_tag, req_tag;
    logic             hit, proc_req, last_ack;

    // Combinational tag lookup from the live fetch address and the latched miss address
    always_comb begin
        proc_idx  = idx_of(wish_s_proc_addr);
        proc_word = word_of(wish_s_proc_addr);
        proc_tag  = tag_of(wish_s_proc_addr);
        req_idx   = idx_of(req_addr);
        req_word  = word_of(req_addr);
        req_tag   = tag_of(req_addr);
        hit       = valid[proc_idx] && (tag_mem[proc_idx] == proc_tag);
        proc_req  = wish_s_proc_cyc && wish_s_proc_stb;
        last_ack  = wish_p_rom_cyc && wish_p_rom_ack && (cnt == LAST_WORD);
    end

    // The cache only ever issues full-width reads
    assign wish_p_rom_we      = 1'b0;
    assign wish_p_rom_sel     = '1;
    assign wish_p_rom_tgd     = 1'b0;
    assign wish_p_rom_dat_i_p = '0;

    logic unused_inputs;
    assign unused_inputs = ^{wish_s_proc_sel, wish_s_proc_tgd, wish_s_proc_dat_o_s};

    // Control FSM: hit/write acknowledge, line refill and the post-refill response
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state               <= IDLE;
            valid               <= '0;
            wish_s_proc_ack     <= 1'b0;
            wish_s_proc_dat_i_s <= '0;
            wish_p_rom_cyc      <= 1'b0;
            wish_p_rom_stb      <= 1'b0;
            wish_p_rom_addr     <= '0;
            cnt                 <= '0;
            req_addr            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wish_s_proc_ack <= 1'b0;
                    if (proc_req) begin
                        if (wish_s_proc_we) begin
                            state               <= WR_ACK;
                            wish_s_proc_ack     <= 1'b1;
                            wish_s_proc_dat_i_s <= '0;
                        end else if (hit) begin
                            state               <= HIT_ACK;
                            wish_s_proc_ack     <= 1'b1;
                            wish_s_proc_dat_i_s <= data_mem[proc_idx][proc_word];
                        end else begin
                            state           <= REFILL;
                            cnt             <= '0;
                            req_addr        <= wish_s_proc_addr;
                            wish_p_rom_cyc  <= 1'b1;
                            wish_p_rom_stb  <= 1'b1;
                            wish_p_rom_addr <= line_base(wish_s_proc_addr);
                        end
                    end
                end
                HIT_ACK, WR_ACK, RESP: begin
                    wish_s_proc_ack <= 1'b0;
                    state           <= IDLE;
                end
                REFILL: begin
                    if (wish_p_rom_cyc && wish_p_rom_ack) begin
                        data_mem[req_idx][cnt] <= wish_p_rom_dat_o_p;
                        if (last_ack) begin
                            valid[req_idx]   <= 1'b1;
                            tag_mem[req_idx] <= req_tag;
                            wish_p_rom_cyc   <= 1'b0;
                            wish_p_rom_stb   <= 1'b0;
                            cnt              <= '0;
                            if (proc_req) begin
                                // The requested word may be the one arriving right now
                                state               <= RESP;
                                wish_s_proc_ack     <= 1'b1;
                                wish_s_proc_dat_i_s <= (req_word == LAST_WORD) ? wish_p_rom_dat_o_p
                                                                               : data_mem[req_idx][req_word];
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt             <= cnt + CNT_W'(1);
                            wish_p_rom_addr <= wish_p_rom_addr + ADDR_SIZE'(BYTES);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/icache_rom.md
Name: icache_rom

Overview:
- Read-only, direct-mapped instruction cache between the processor fetch port and the ROM.
- Upstream: its `wish_s_proc` port is driven by the memory controller's cache-ROM primary port.
- Downstream: its `wish_p_rom` port drives the memory controller's cache-ROM secondary port, which arbitrates ROM access.
- Hits are answered with one-cycle latency. Misses refill a whole line from ROM with sequential single Wishbone reads.

Parameters:
- ADDR_SIZE, 32, address width of both Wishbone ports.
- DATA_SIZE, 32, data width in bits; multiple of 8.
- LINE_WORDS, 4, words per line; power of 2, ≥1.
- LINES, 16, number of lines; power of 2, ≥2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- wish_s_proc  wishbone_if.secondary  ADDR_SIZE/DATA_SIZE  fetch requests (cyc, stb, we, sel, tgd, addr, dat_o_s in; ack, dat_i_s out).
- wish_p_rom  wishbone_if.primary  ADDR_SIZE/DATA_SIZE  refill reads to ROM (cyc, stb, we, sel, tgd, addr, dat_i_p out; ack, dat_o_p in).

Behaviour:
- Address split, LSB first:
  - byte offset: log2(DATA_SIZE/8)
  - word offset: log2(LINE_WORDS)
  - index: log2(LINES)
  - tag: remaining bits
- Storage:
  - valid[LINES], tag[LINES] and data[LINES][LINE_WORDS] are registers.
  - Lookup is combinational from the current proc addr.
- Reset (reset_n=0 at an edge):
  - state=IDLE.
  - All valid bits cleared.
  - proc ack=0, dat_i_s=0.
  - rom cyc=stb=0, addr=0, word counter=0.
  - Reset overrides every other event, including mid-refill. A partly fetched line is never marked valid.
- Constant ROM outputs: we=0, sel=all ones, tgd=0, dat_i_p=0.
- States:
  - IDLE:
    - Request = proc cyc&stb.
    - Request & we=1 → WR_ACK. No ROM access; the write is discarded.
    - Request & we=0 & hit (valid[idx] & tag match) → HIT_ACK. Data word latched into dat_i_s.
    - Request & we=0 & miss → REFILL. Counter=0; request addr latched; rom cyc=stb=1, addr=line base.
  - HIT_ACK / WR_ACK:
    - proc ack=1 for exactly this cycle, then → IDLE.
    - dat_i_s holds the hit word, or 0 for a write.
  - REFILL:
    - rom cyc=stb held high; addr = line base + counter·(DATA_SIZE/8).
    - On each rom ack: data[idx][counter] ← dat_o_p, counter++, addr advances the next cycle. cyc/stb stay high across words.
    - On the ack of word LINE_WORDS−1: valid[idx]=1, tag[idx]=latched tag, cyc=stb=0.
    - Then → RESP if proc cyc&stb is still high, else → IDLE (line kept, no ack).
  - RESP:
    - proc ack=1 one cycle, dat_i_s = the requested word from the latched address, then → IDLE.
- Proc rules:
  - Proc holds cyc/stb/addr stable until ack.
  - ack is a single-cycle pulse.
  - A request still present in IDLE after an ack is treated as a new request.
- Latency, with ROM answering one cycle after stb:
  - Hit: ack in the cycle after the request is seen in IDLE.
  - Miss: 1 + 2·LINE_WORDS + 1 cycles to ack.
- ROM ack arriving while cyc=0 is ignored.

Test Plan:
All scenarios use the defaults, and the ROM model returns dat = addr with ack one cycle after stb.
1. Reset, then read 0x104 → ROM reads 0x100, 0x104, 0x108, 0x10C in order; a single proc ack with dat_i_s=0x104; ROM cyc low afterwards.
2. After 1, read 0x10C → proc ack the next cycle with 0x10C; ROM cyc stays 0 throughout.
3. After 2, read 0x504 (same index 0, different tag) → refill 0x500–0x50C, ack with 0x504; a following read of 0x100 misses again and refills 0x100–0x10C.
4. Reset asserted during the third refill word of 0x200 → ROM cyc/stb low at the next edge, no proc ack; after reset, read 0x104 misses (full 4-word refill).
5. Write 0xDEAD to 0x104 after line 0x100 is cached → ack one cycle later, no ROM activity; a following read of 0x104 hits and returns 0x104.
6. Proc drops cyc after the second refill word of 0x300 → refill completes with no ack; a subsequent read of 0x308 hits with one-cycle latency, returning 0x308.
